// File: rtl/dac_data_rx_align.sv
// Receive-side slot aligner for the x2 DDR DAC link. It recovers the slot
// offset from frame rising edges and reassembles the two-channel sample word.
// It also checks even parity per sample and keeps saturating error counters.
module dac_data_rx_align #(
  parameter int LOCK_FRAMES = 4,
  parameter int LOSS_FRAMES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             i_sclk,
  input  logic             i_rst,
  input  logic             i_rx_vld,
  input  logic [15:0]      i_rx_d0,
  input  logic [15:0]      i_rx_d1,
  input  logic [15:0]      i_rx_d2,
  input  logic [15:0]      i_rx_d3,
  input  logic [3:0]       i_rx_parity,
  input  logic [3:0]       i_rx_frame,
  input  logic [3:0]       i_rx_sync,
  input  logic             i_clr_cnt,
  output logic             o_locked,
  output logic [1:0]       o_offset,
  output logic             o_samples_vld,
  output logic [15:0]      o_chan_a_sample_0,
  output logic [15:0]      o_chan_a_sample_1,
  output logic [15:0]      o_chan_b_sample_0,
  output logic [15:0]      o_chan_b_sample_1,
  output logic             o_sync,
  output logic             o_frame,
  output logic [3:0]       o_par_err,
  output logic [CNT_W-1:0] o_par_err_cnt,
  output logic [CNT_W-1:0] o_align_err_cnt
);
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t     state;
  logic [1:0] cand;
  logic [3:0] match, miss;

  // previous valid cycle's slots; edge flags are kept so slot 0 of the
  // previous cycle still knows whether it started a frame
  logic [3:0][15:0] prev_d;
  logic [3:0]       prev_par, prev_sync, prev_frame, prev_edge;
  logic             prev_vld;

  logic [3:0][15:0] cur_d;
  logic [3:0]       cur_edge;
  logic [7:0][15:0] s_d;
  logic [7:0]       s_par, s_sync, s_edge;

  assign cur_d    = {i_rx_d3, i_rx_d2, i_rx_d1, i_rx_d0};
  assign cur_edge = i_rx_frame & ~{i_rx_frame[2:0], prev_frame[3]};
  assign s_d      = {cur_d, prev_d};
  assign s_par    = {i_rx_parity, prev_par};
  assign s_sync   = {i_rx_sync, prev_sync};
  assign s_edge   = {cur_edge, prev_edge};

  logic       edge_any, edge_multi, mis;
  logic [1:0] edge_pos;

  // lowest-slot edge wins; more than one edge is an alignment error
  always_comb begin
    edge_pos = 2'd0;
    for (int j = 3; j >= 0; j--)
      if (cur_edge[j]) edge_pos = 2'(j);
    edge_any   = i_rx_vld && (cur_edge != 4'd0);
    edge_multi = edge_any && ((cur_edge & (cur_edge - 4'd1)) != 4'd0);
    mis        = edge_any && (((state == VERIFY) && (edge_pos != cand)) ||
                              ((state == LOCKED) && (edge_pos != o_offset)));
  end

  logic [3:0][15:0] w_d;
  logic [3:0]       w_err, w_perr;
  logic             w_vld, w_sync, w_frame;
  logic [2:0]       pop;

  // aligned word = S[offset .. offset+3] across prev and current slots
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_d[k]   = s_d[{1'b0, o_offset} + 3'(k)];
      w_err[k] = (^w_d[k]) != s_par[{1'b0, o_offset} + 3'(k)];
    end
    w_vld   = (state == LOCKED) && i_rx_vld && prev_vld;
    w_sync  = s_sync[{1'b0, o_offset}];
    w_frame = s_edge[{1'b0, o_offset}];
    w_perr  = w_vld ? w_err : 4'd0;
    pop     = {2'b0, w_perr[0]} + {2'b0, w_perr[1]} + {2'b0, w_perr[2]} + {2'b0, w_perr[3]};
  end

  logic [CNT_W:0] par_sum, align_sum;
  assign par_sum   = {1'b0, o_par_err_cnt} + (CNT_W+1)'(pop);
  assign align_sum = {1'b0, o_align_err_cnt} + (CNT_W+1)'({1'b0, edge_multi} + {1'b0, mis});

  // slot history: captured on valid cycles, held across gaps
  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      prev_d     <= '0;
      prev_par   <= '0;
      prev_sync  <= '0;
      prev_frame <= '0;
      prev_edge  <= '0;
      prev_vld   <= 1'b0;
    end else if (i_rx_vld) begin
      prev_d     <= cur_d;
      prev_par   <= i_rx_parity;
      prev_sync  <= i_rx_sync;
      prev_frame <= i_rx_frame;
      prev_edge  <= cur_edge;
      prev_vld   <= 1'b1;
    end else begin
      prev_vld   <= 1'b0;
    end
  end

  // alignment FSM; offset is only updated on lock and held after loss
  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      state    <= SEARCH;
      cand     <= 2'd0;
      match    <= 4'd0;
      miss     <= 4'd0;
      o_offset <= 2'd0;
      o_locked <= 1'b0;
    end else if (edge_any) begin
      case (state)
        SEARCH: begin
          cand  <= edge_pos;
          match <= 4'd1;
          if (LOCK_FRAMES == 1) begin
            state    <= LOCKED;
            o_locked <= 1'b1;
            o_offset <= edge_pos;
            miss     <= 4'd0;
          end else begin
            state <= VERIFY;
          end
        end
        VERIFY: begin
          if (edge_pos == cand) begin
            if (match + 4'd1 == 4'(LOCK_FRAMES)) begin
              state    <= LOCKED;
              o_locked <= 1'b1;
              o_offset <= cand;
              miss     <= 4'd0;
            end else begin
              match <= match + 4'd1;
            end
          end else begin
            cand  <= edge_pos;
            match <= 4'd1;
          end
        end
        LOCKED: begin
          if (edge_pos == o_offset) begin
            miss <= 4'd0;
          end else if (miss + 4'd1 == 4'(LOSS_FRAMES)) begin
            state    <= SEARCH;
            o_locked <= 1'b0;
            miss     <= 4'd0;
          end else begin
            miss <= miss + 4'd1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

  // registered aligned word; everything but the valid flag is zero when invalid
  always_ff @(posedge i_sclk) begin
    if (i_rst || !w_vld) begin
      o_samples_vld     <= 1'b0;
      o_chan_a_sample_0 <= '0;
      o_chan_a_sample_1 <= '0;
      o_chan_b_sample_0 <= '0;
      o_chan_b_sample_1 <= '0;
      o_sync            <= 1'b0;
      o_frame           <= 1'b0;
      o_par_err         <= '0;
    end else begin
      o_samples_vld     <= 1'b1;
      o_chan_a_sample_0 <= w_d[0];
      o_chan_a_sample_1 <= w_d[1];
      o_chan_b_sample_0 <= w_d[2];
      o_chan_b_sample_1 <= w_d[3];
      o_sync            <= w_sync;
      o_frame           <= w_frame;
      o_par_err         <= w_err;
    end
  end

  // saturating error counters; clear beats a same-cycle increment
  always_ff @(posedge i_sclk) begin
    if (i_rst || i_clr_cnt) begin
      o_par_err_cnt   <= '0;
      o_align_err_cnt <= '0;
    end else begin
      o_par_err_cnt   <= par_sum[CNT_W]   ? '1 : par_sum[CNT_W-1:0];
      o_align_err_cnt <= align_sum[CNT_W] ? '1 : align_sum[CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_dac_data_rx_align.sv
// Bench for dac_data_rx_align: directed bring-up scenarios plus a randomized
// slot stream, all checked against a slot-history model kept here.
module tb_dac_data_rx_align;
  localparam int LOCK = 4, LOSS = 2, CW = 16;
  localparam int MS_SEARCH = 0, MS_VERIFY = 1, MS_LOCKED = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0, rst = 1'b1, vld = 1'b0, clr = 1'b0;
  logic [15:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [3:0]  par = '0, frm = '0, syn = '0;
  logic        locked, samples_vld, o_sync, o_frame;
  logic [1:0]  offset;
  logic [15:0] a0, a1, b0, b1;
  logic [3:0]  perr;
  logic [CW-1:0] pcnt, acnt;

  always #5 clk = ~clk;

  dac_data_rx_align #(.LOCK_FRAMES(LOCK), .LOSS_FRAMES(LOSS), .CNT_W(CW)) dut (
    .i_sclk(clk), .i_rst(rst), .i_rx_vld(vld),
    .i_rx_d0(d0), .i_rx_d1(d1), .i_rx_d2(d2), .i_rx_d3(d3),
    .i_rx_parity(par), .i_rx_frame(frm), .i_rx_sync(syn), .i_clr_cnt(clr),
    .o_locked(locked), .o_offset(offset), .o_samples_vld(samples_vld),
    .o_chan_a_sample_0(a0), .o_chan_a_sample_1(a1),
    .o_chan_b_sample_0(b0), .o_chan_b_sample_1(b1),
    .o_sync(o_sync), .o_frame(o_frame), .o_par_err(perr),
    .o_par_err_cnt(pcnt), .o_align_err_cnt(acnt)
  );

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: flat slot history ----------------
  logic [15:0] hd[8];
  bit          hp[8], hf[8], hs[8];
  bit          m_pvld;
  int          m_state, m_cand, m_match, m_miss, m_off, m_pcnt, m_acnt;
  logic [15:0] sd[8];
  bit          sp[8], ss[8], sf[9];   // sf[k+1] is frame of S[k]; sf[0] is S[-1]
  int          ne, pos, inc, pop;
  bit          e_vld = 0, e_locked = 0, e_frame = 0, e_sync = 0;
  logic [15:0] e_w[4];
  logic [3:0]  e_perr = '0;
  int          e_off = 0;

  task automatic model_step();
    logic [15:0] cd[4];
    cd[0] = d0; cd[1] = d1; cd[2] = d2; cd[3] = d3;
    if (rst) begin
      for (int k = 0; k < 8; k++) begin hd[k] = '0; hp[k] = 0; hf[k] = 0; hs[k] = 0; end
      m_pvld = 0; m_state = MS_SEARCH; m_cand = 0; m_match = 0; m_miss = 0; m_off = 0;
      m_pcnt = 0; m_acnt = 0;
      e_vld = 0; e_frame = 0; e_sync = 0; e_perr = '0;
      for (int n = 0; n < 4; n++) e_w[n] = '0;
    end else begin
      sf[0] = hf[3];
      for (int k = 0; k < 4; k++) begin
        sd[k] = hd[4+k]; sp[k] = hp[4+k]; ss[k] = hs[4+k]; sf[k+1] = hf[4+k];
        sd[4+k] = cd[k]; sp[4+k] = par[k]; ss[4+k] = syn[k]; sf[5+k] = frm[k];
      end
      e_vld = (m_state == MS_LOCKED) && vld && m_pvld;
      e_perr = '0; e_frame = 0; e_sync = 0;
      for (int n = 0; n < 4; n++) e_w[n] = '0;
      if (e_vld) begin
        for (int n = 0; n < 4; n++) begin
          e_w[n] = sd[m_off+n];
          e_perr[n] = (^sd[m_off+n]) != sp[m_off+n];
        end
        e_frame = sf[m_off+1] && !sf[m_off];
        e_sync  = ss[m_off];
      end
      pop = $countones(e_perr);
      ne = 0; pos = -1;
      if (vld)
        for (int j = 0; j < 4; j++)
          if (sf[5+j] && !sf[4+j]) begin ne++; if (pos < 0) pos = j; end
      inc = (ne > 1) ? 1 : 0;
      if (ne > 0) begin
        if (m_state == MS_SEARCH) begin
          m_cand = pos; m_match = 1;
          if (LOCK == 1) begin m_state = MS_LOCKED; m_off = pos; m_miss = 0; end
          else m_state = MS_VERIFY;
        end else if (m_state == MS_VERIFY) begin
          if (pos == m_cand) begin
            m_match++;
            if (m_match >= LOCK) begin m_state = MS_LOCKED; m_off = m_cand; m_miss = 0; end
          end else begin
            m_cand = pos; m_match = 1; inc++;
          end
        end else begin
          if (pos == m_off) m_miss = 0;
          else begin
            m_miss++; inc++;
            if (m_miss >= LOSS) begin m_state = MS_SEARCH; m_miss = 0; end
          end
        end
      end
      if (clr) begin m_pcnt = 0; m_acnt = 0; end
      else begin
        m_pcnt = (m_pcnt + pop > CMAX) ? CMAX : m_pcnt + pop;
        m_acnt = (m_acnt + inc > CMAX) ? CMAX : m_acnt + inc;
      end
      if (vld) begin
        for (int k = 0; k < 4; k++) begin
          hd[k] = hd[4+k]; hp[k] = hp[4+k]; hf[k] = hf[4+k]; hs[k] = hs[4+k];
          hd[4+k] = cd[k]; hp[4+k] = par[k]; hf[4+k] = frm[k]; hs[4+k] = syn[k];
        end
        m_pvld = 1;
      end else m_pvld = 0;
    end
    e_locked = (m_state == MS_LOCKED);
    e_off = m_off;
  endtask

  initial forever begin @(posedge clk); model_step(); end

  // compare every cycle, away from the active edge
  initial forever begin
    @(negedge clk);
    chk("locked", locked, e_locked);
    chk("offset", offset, e_off);
    chk("samples_vld", samples_vld, e_vld);
    chk("a_s0", a0, e_w[0]);
    chk("a_s1", a1, e_w[1]);
    chk("b_s0", b0, e_w[2]);
    chk("b_s1", b1, e_w[3]);
    chk("sync", o_sync, e_sync);
    chk("frame", o_frame, e_frame);
    chk("par_err", perr, e_perr);
    chk("par_err_cnt", pcnt, m_pcnt);
    chk("align_err_cnt", acnt, m_acnt);
  end

  // ---------------- stimulus ----------------
  int g = 0;                       // global slot index of current slot 0
  logic [15:0] ld[4], pld[4];      // data of the last two valid cycles

  task automatic cyc(input bit v, input int off, input logic [3:0] flip,
                     input bit c, input bit rnd);
    logic [15:0] dd[4];
    logic [3:0]  f;
    for (int k = 0; k < 4; k++) begin
      dd[k] = 16'($urandom);
      f[k]  = ((g + k + 16 - off) % 16) < 4;
    end
    if (rnd) f = 4'($urandom);
    d0 = dd[0]; d1 = dd[1]; d2 = dd[2]; d3 = dd[3];
    for (int k = 0; k < 4; k++) par[k] = (^dd[k]) ^ flip[k];
    frm = f; syn = 4'($urandom); vld = v; clr = c;
    if (v) begin
      g += 4;
      for (int k = 0; k < 4; k++) begin pld[k] = ld[k]; ld[k] = dd[k]; end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 4'h0, 0, 0);
    cyc(0, 0, 4'h0, 0, 0);
    rst = 1'b0;
    g = 0;
  endtask

  initial begin
    int off;
    for (int k = 0; k < 4; k++) begin ld[k] = '0; pld[k] = '0; end
    do_reset();
    chk("rst_locked", locked, 0);
    chk("rst_par_cnt", pcnt, 0);

    // offset 0 lock: edges at cycles 0,4,8,12
    for (int i = 0; i < 12; i++) cyc(1, 0, 4'h0, 0, 0);
    chk("pre_lock", locked, 0);
    cyc(1, 0, 4'h0, 0, 0);
    chk("lock0", locked, 1);
    chk("lock0_off", offset, 0);
    cyc(1, 0, 4'h0, 0, 0);
    chk("w0_vld", samples_vld, 1);
    chk("w0_frame", o_frame, 1);
    chk("w0_a0", a0, pld[0]);
    chk("w0_a1", a1, pld[1]);
    chk("w0_b0", b0, pld[2]);
    chk("w0_b1", b1, pld[3]);
    chk("w0_pcnt", pcnt, 0);

    // parity fault on b_s1 for 5 words
    cyc(1, 0, 4'h0, 1, 0);
    cyc(1, 0, 4'h8, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, (i < 4) ? 4'h8 : 4'h0, 0, 0);
      chk("perr_b1", perr, 4'h8);
    end
    chk("perr_cnt5", pcnt, 5);

    // loss of lock: move frame edges to slot 2
    while (g % 16 != 4) cyc(1, 0, 4'h0, 0, 0);
    cyc(1, 2, 4'h0, 1, 0);
    for (int i = 0; i < 7; i++) cyc(1, 2, 4'h0, 0, 0);
    chk("loss_acnt", acnt, 2);
    chk("loss_locked", locked, 0);
    cyc(1, 2, 4'h0, 0, 0);
    chk("loss_vld", samples_vld, 0);
    for (int i = 0; i < 15; i++) cyc(1, 2, 4'h0, 0, 0);
    chk("relock", locked, 1);
    chk("relock_off", offset, 2);
    chk("relock_acnt", acnt, 2);

    // rotated by 3
    do_reset();
    for (int i = 0; i < 13; i++) cyc(1, 3, 4'h0, 0, 0);
    chk("lock3", locked, 1);
    chk("lock3_off", offset, 3);
    cyc(1, 3, 4'h0, 0, 0);
    chk("r3_a0", a0, pld[3]);
    chk("r3_a1", a1, ld[0]);
    chk("r3_b0", b0, ld[1]);
    chk("r3_b1", b1, ld[2]);
    chk("r3_frame", o_frame, 1);

    // valid gap while locked
    cyc(0, 3, 4'h0, 0, 0);
    chk("gap_vld0", samples_vld, 0);
    cyc(1, 3, 4'h0, 0, 0);
    chk("gap_vld1", samples_vld, 0);
    chk("gap_locked", locked, 1);
    cyc(1, 3, 4'h0, 0, 0);
    chk("gap_vld2", samples_vld, 1);

    // reset mid-lock
    rst = 1'b1;
    cyc(1, 3, 4'h0, 0, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_vld", samples_vld, 0);
    chk("midrst_a0", a0, 0);
    rst = 1'b0; g = 0;

    // randomized stream
    off = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(63) == 0) off = $urandom_range(3);
      rst = ($urandom_range(699) == 0);
      cyc($urandom_range(9) != 0, off,
          ($urandom_range(9) == 0) ? 4'($urandom) : 4'h0,
          $urandom_range(49) == 0, $urandom_range(19) == 0);
    end
    rst = 1'b0;

    // saturation and clear priority
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 0, 4'h0, 0, 0);
    for (int i = 0; i < 16400; i++) cyc(1, 0, 4'hF, 0, 0);
    chk("sat", pcnt, 16'hFFFF);
    for (int i = 0; i < 3; i++) cyc(1, 0, 4'hF, 0, 0);
    chk("sat_hold", pcnt, 16'hFFFF);
    cyc(1, 0, 4'hF, 1, 0);
    chk("clr_prio", pcnt, 0);
    cyc(1, 0, 4'h0, 0, 0);
    chk("after_clr", pcnt, 4);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
